// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// Each neuron has an adaptive threshold and a refractory period. One update is
// accepted per cycle, and the result is held in a single output register.
module lif_array #(
    parameter int N_NEURONS   = 4,
    parameter int W           = 8,
    parameter int CW          = 12,
    parameter int LEAK_NUM    = 14,
    parameter int THR_INIT    = 50,
    parameter int THR_MIN     = 50,
    parameter int THR_MAX     = 250,
    parameter int THR_SHIFT   = 2,
    parameter int DECAY_DELAY = 5,
    parameter int REFRAC      = 2,
    parameter int RESET_MODE  = 0,
    localparam int IW         = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic [CW-1:0] current,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [W-1:0]  out_state,
    output logic          out_spike
);

    // Widths of the refractory and quiet counters. Each is kept at least one bit wide.
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int QW = (DECAY_DELAY > 0) ? $clog2(DECAY_DELAY + 1) : 1;
    localparam logic [W-1:0] VMAX = '1;

    logic [W-1:0]  v_mem     [N_NEURONS];
    logic [W-1:0]  thr_mem   [N_NEURONS];
    logic [RW-1:0] ref_mem   [N_NEURONS];
    logic [QW-1:0] quiet_mem [N_NEURONS];

    logic          accept;
    logic          idx_ok;
    logic [W-1:0]  cur_v;
    logic [W-1:0]  cur_thr;
    logic [RW-1:0] cur_ref;
    logic [QW-1:0] cur_quiet;
    logic [W+7:0]  prod;
    logic [CW:0]   sum;
    logic [W-1:0]  vs;
    logic [CW:0]   thr_sum;
    logic [W-1:0]  thr_sat;
    logic          decay;
    logic [QW-1:0] quiet_inc;
    logic [W-1:0]  nv;
    logic [W-1:0]  nthr;
    logic [RW-1:0] nref;
    logic [QW-1:0] nquiet;
    logic [W-1:0]  res_state;
    logic          res_spike;

    // A new request can enter whenever the output slot is empty or is being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign idx_ok   = int'(in_idx) < N_NEURONS;

    // Read the addressed neuron, then compute its leaked, integrated and saturated
    // membrane value, together with the threshold candidates.
    always_comb begin
        cur_v     = v_mem[in_idx];
        cur_thr   = thr_mem[in_idx];
        cur_ref   = ref_mem[in_idx];
        cur_quiet = quiet_mem[in_idx];
        prod      = (W+8)'(cur_v) * (W+8)'(LEAK_NUM);
        sum       = {1'b0, current} + (CW+1)'(prod >> 4);
        vs        = (sum > (CW+1)'(VMAX)) ? VMAX : sum[W-1:0];
        thr_sum   = (CW+1)'(cur_thr) + (CW+1)'(current >> THR_SHIFT);
        thr_sat   = (thr_sum > (CW+1)'(THR_MAX)) ? W'(THR_MAX) : thr_sum[W-1:0];
        decay     = (cur_quiet >= QW'(DECAY_DELAY)) && (cur_thr > W'(THR_MIN));
        quiet_inc = (cur_quiet >= QW'(DECAY_DELAY)) ? cur_quiet : cur_quiet + QW'(1);
    end

    // Select the next neuron state and the result. There are three cases:
    // refractory, spike, and plain integration.
    always_comb begin
        nv        = cur_v;
        nthr      = cur_thr;
        nref      = cur_ref;
        nquiet    = cur_quiet;
        res_state = '0;
        res_spike = 1'b0;
        if (cur_ref != '0) begin
            nv     = '0;
            nref   = cur_ref - RW'(1);
            nquiet = quiet_inc;
            nthr   = decay ? cur_thr - W'(1) : cur_thr;
        end else if (vs >= cur_thr) begin
            nv        = (RESET_MODE == 1) ? vs - cur_thr : '0;
            nref      = RW'(REFRAC);
            nquiet    = '0;
            nthr      = thr_sat;
            res_state = vs;
            res_spike = 1'b1;
        end else begin
            nv        = vs;
            nquiet    = quiet_inc;
            nthr      = decay ? cur_thr - W'(1) : cur_thr;
            res_state = vs;
        end
    end

    // Per-neuron state storage. Only the addressed neuron is written, and only on a
    // valid accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]     <= '0;
                thr_mem[i]   <= W'(THR_INIT);
                ref_mem[i]   <= '0;
                quiet_mem[i] <= '0;
            end
        end else if (accept && idx_ok) begin
            v_mem[in_idx]     <= nv;
            thr_mem[in_idx]   <= nthr;
            ref_mem[in_idx]   <= nref;
            quiet_mem[in_idx] <= nquiet;
        end
    end

    // Output register. It loads on a valid accept, clears when drained, and holds
    // while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_state <= '0;
            out_spike <= 1'b0;
        end else if (accept && idx_ok) begin
            out_valid <= 1'b1;
            out_idx   <= in_idx;
            out_state <= res_state;
            out_spike <= res_spike;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// Scoreboard testbench for lif_array.
// Directed scenarios plus randomized traffic are checked against a behavioural neuron model.
module tb_lif_array;

    localparam int N      = 4;
    localparam int IW     = 2;
    localparam int LEAK   = 14;
    localparam int TINIT  = 50;
    localparam int TMIN   = 50;
    localparam int TMAX   = 250;
    localparam int TSHIFT = 2;
    localparam int DD     = 5;
    localparam int RFR    = 2;
    localparam int VMAX   = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_idx = '0;
    logic [11:0]   current = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_idx;
    logic [7:0]    out_state;
    logic          out_spike;

    typedef struct {
        int idx;
        int state;
        int spike;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mv[N];
    int   mthr[N];
    int   mref[N];
    int   mq[N];
    bit   rand_ready = 1'b0;

    lif_array dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .current   (current),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_state (out_state),
        .out_spike (out_spike)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mv[i]   = 0;
            mthr[i] = TINIT;
            mref[i] = 0;
            mq[i]   = 0;
        end
    endfunction

    // A quiet (non-spiking) update. The threshold decay is decided on the quiet
    // count from before this update.
    function automatic void quietTick(input int i);
        if (mq[i] >= DD && mthr[i] > TMIN) mthr[i] = mthr[i] - 1;
        if (mq[i] < DD) mq[i] = mq[i] + 1;
    endfunction

    function automatic void modelStep(input int i, input int cur, output int st, output int sp);
        int s;
        int v;
        if (mref[i] > 0) begin
            mref[i] = mref[i] - 1;
            mv[i]   = 0;
            st      = 0;
            sp      = 0;
            quietTick(i);
        end else begin
            s  = cur + (mv[i] * LEAK) / 16;
            v  = (s > VMAX) ? VMAX : s;
            st = v;
            sp = (v >= mthr[i]) ? 1 : 0;
            if (sp == 1) begin
                mv[i]   = 0;
                mref[i] = RFR;
                mq[i]   = 0;
                mthr[i] = mthr[i] + (cur >> TSHIFT);
                if (mthr[i] > TMAX) mthr[i] = TMAX;
            end else begin
                mv[i] = v;
                quietTick(i);
            end
        end
    endfunction

    // Issue one request and wait, within a cycle budget, until it is accepted.
    // At the accept, record the expected result: the model's, or a given directed value.
    task automatic applyStimulus(input int idx, input int cur, input int exp_state = -1, input int exp_spike = -1);
        bit   got = 1'b0;
        int   st;
        int   sp;
        exp_t e;
        in_valid = 1'b1;
        in_idx   = idx[IW-1:0];
        current  = cur[11:0];
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                modelStep(idx, cur, st, sp);
                e.idx   = idx;
                e.state = (exp_state >= 0) ? exp_state : st;
                e.spike = (exp_spike >= 0) ? exp_spike : sp;
                exp_q.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    // Monitor: every result the DUT hands over is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_idx", int'(out_idx), e.idx);
                    checkOutput("out_state", int'(out_state), e.state);
                    checkOutput("out_spike", int'(out_spike), e.spike);
                end
            end
        end
    end

    // Random backpressure on the output during the randomized phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        modelReset();

        // Reset and the idle state after release.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid_rel", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // First accept with zero current.
        applyStimulus(0, 0, 0, 0);

        // Integration with leak, ending in a spike. Refractory updates follow.
        applyStimulus(0, 20, 20, 0);
        applyStimulus(0, 20, 37, 0);
        applyStimulus(0, 20, 52, 1);
        applyStimulus(0, 20, 0, 0);
        applyStimulus(0, 20, 0, 0);
        applyStimulus(0, 20, 20, 0);

        // Saturation and threshold ceiling. Neuron 2 is independent of neuron 1.
        applyStimulus(1, 4095, 255, 1);
        applyStimulus(2, 10, 10, 0);

        // Output stall: the result must hold and in_ready must drop.
        applyStimulus(2, 5, 13, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_idx    = 2'd0;
        current   = 12'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", int'(in_ready), 0);
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_out_idx", int'(out_idx), 2);
            checkOutput("stall_out_state", int'(out_state), 13);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(2, 0, 11, 0);

        // Threshold of neuron 3 raised to 55 by a spike, then decays back to the floor.
        applyStimulus(3, 20, 20, 0);
        applyStimulus(3, 20, 37, 0);
        applyStimulus(3, 20, 52, 1);
        for (int k = 0; k < 10; k++) applyStimulus(3, 0, 0, 0);
        applyStimulus(3, 50, 50, 1);

        // Reset while a result is pending. That result is discarded.
        applyStimulus(0, 20);
        out_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_out_idx", int'(out_idx), 0);
        checkOutput("midreset_out_state", int'(out_state), 0);
        checkOutput("midreset_out_spike", int'(out_spike), 0);
        exp_q.delete();
        modelReset();
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 20, 20, 0);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) n = $urandom_range(0, 4095);
            else n = $urandom_range(0, 45);
            applyStimulus($urandom_range(0, N - 1), n);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Drain the scoreboard.
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_remaining", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
